// File: rtl/threshold_sweep_checker.sv
// -----------------------------------------------------------------------------
// threshold_sweep_checker
//
// Exhaustive stimulus driver and response checker for an N-input threshold
// (majority-style) combinational function. Once started, it walks x through
// every input combination in ascending order. Each vector is held for
// SETTLE+1 cycles and the function output f_in is sampled on the last of
// those cycles. The sampled value is compared against
// (popcount(x) >= THRESH).
//
// Ports
//   clk            : rising-edge clock
//   rst_n          : asynchronous active-low reset
//   start          : one-cycle sweep request, honoured only in IDLE
//   x              : stimulus vector, x[N_IN-1] is the MSB (x1)
//   f_in           : output of the function under test
//   busy           : high for the whole sweep (WAIT state)
//   done           : one-cycle pulse when the sweep completes
//   ones_count     : number of vectors for which f_in sampled 1
//   mismatch_count : number of vectors for which f_in != expected
//   first_fail_vec : x of the first mismatch, meaningful when fail_seen=1
//   fail_seen      : at least one mismatch in the current/last sweep
// -----------------------------------------------------------------------------
module threshold_sweep_checker #(
  parameter int N_IN   = 4,
  parameter int THRESH = 3,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] x,
  input  logic            f_in,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   ones_count,
  output logic [N_IN:0]   mismatch_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            fail_seen
);

  localparam int PCW = $clog2(N_IN + 1);

  localparam logic [3:0]    SETTLE_V = 4'(SETTLE);
  localparam logic [N_IN:0] CNT_ONE  = (N_IN+1)'(1);
  localparam logic [N_IN-1:0] VEC_ONE = N_IN'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] settle_cnt;

  // ---------------------------------------------------------------------------
  // Expected value: popcount(x) >= THRESH, built as a prefix-sum chain.
  // ---------------------------------------------------------------------------
  logic [PCW-1:0] pc [N_IN+1];
  logic           expected;

  assign pc[0] = '0;
  for (genvar i = 0; i < N_IN; i++) begin : g_pc
    assign pc[i+1] = pc[i] + PCW'(x[i]);
  end

  assign expected = (int'(pc[N_IN]) >= THRESH);

  // Sample happens on the last cycle a vector is held.
  logic sample, last_vec, accept, mismatch;

  assign accept   = (state == S_IDLE) && start;
  assign sample   = (state == S_WAIT) && (settle_cnt == 4'd0);
  assign last_vec = &x;
  assign mismatch = (f_in != expected);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_WAIT;
      S_WAIT:  if (sample && last_vec) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Derived from the next state and registered below so busy
  // and done come straight from flops.
  // ---------------------------------------------------------------------------
  logic busy_d, done_d;

  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_nxt)
      S_WAIT:  busy_d = 1'b1;
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: stimulus vector, settle counter and result registers.
  // Results are cleared only when a new sweep is accepted, so they hold in
  // IDLE after a sweep for software to read.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x              <= '0;
      settle_cnt     <= 4'd0;
      ones_count     <= '0;
      mismatch_count <= '0;
      first_fail_vec <= '0;
      fail_seen      <= 1'b0;
    end else if (accept) begin
      x              <= '0;
      settle_cnt     <= SETTLE_V;
      ones_count     <= '0;
      mismatch_count <= '0;
      first_fail_vec <= '0;
      fail_seen      <= 1'b0;
    end else if (state == S_WAIT) begin
      if (!sample) begin
        settle_cnt <= settle_cnt - 4'd1;
      end else begin
        if (f_in) ones_count <= ones_count + CNT_ONE;
        if (mismatch) begin
          mismatch_count <= mismatch_count + CNT_ONE;
          if (!fail_seen) begin
            first_fail_vec <= x;
            fail_seen      <= 1'b1;
          end
        end
        // At all-ones the FSM leaves WAIT; x parks at all-ones.
        if (!last_vec) begin
          x          <= x + VEC_ONE;
          settle_cnt <= SETTLE_V;
        end
      end
    end
  end

endmodule
